multicycle_cpu: RTL and testbench

- Parametrised multicycle successor to the 16-bit-instruction single-cycle core.
- One FSM sequences fetch, decode, execute and memory states.
- Separate instruction and data memory ports, each with a req/ack handshake, so the core runs against wait-state memories.
- Keeps the Show debug output and adds halt and show-valid signalling.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/cpu_alu.sv | 24 ++
 rtl/multicycle_cpu.sv | 108 ++++++++++
 tb/tb_multicycle_cpu.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, state, flag and ALU types for the multicycle core
package cpu_pkg;
  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR   = 4'h3,
    OP_ADDI = 4'h4, OP_LDI = 4'h5, OP_LD  = 4'h6, OP_ST   = 4'h7,
    OP_BZ   = 4'h8, OP_JMP = 4'h9, OP_SHOW = 4'hA, OP_HALT = 4'hF
  } opcode_t;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, HALTED} state_t;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_t;
endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational add/sub/and/or with NZCV flags
module cpu_alu import cpu_pkg::*; #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] result,
  output flags_t            flags
);
  logic sub, arith;
  logic [DATA_W-1:0] bb;
  logic [DATA_W:0] sum;
  // subtract is a + ~b + 1, so carry out of 1 means no borrow
  always_comb begin
    sub = op == ALU_SUB;
    arith = op == ALU_ADD || op == ALU_SUB;
    bb = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {{DATA_W{1'b0}}, sub};
    result = op == ALU_AND ? a & b : op == ALU_OR ? a | b : sum[DATA_W-1:0];
    flags = {result[DATA_W-1], result == '0, arith & sum[DATA_W],
             arith & (a[DATA_W-1] == bb[DATA_W-1]) & (result[DATA_W-1] != a[DATA_W-1])};
  end
endmodule

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: 16-bit-instruction multicycle core with req/ack instruction and data ports
module multicycle_cpu import cpu_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              show_valid,
  output logic [1:0]        show_sel,
  output logic [DATA_W-1:0] show_data,
  output logic              halted
);
  state_t state, state_nx;
  logic live;
  logic [15:0] ir;
  logic [ADDR_W-1:0] pc, imm_a;
  logic [DATA_W-1:0] regs [16];
  logic [DATA_W-1:0] a, b, alu_b, alu_y, imm_d;
  flags_t flags, alu_f;
  opcode_t op;
  logic [3:0] rd, rs, rt;
  logic alu_wr;
  alu_op_t alu_op;

  assign op = opcode_t'(ir[15:12]);
  assign rd = ir[11:8];
  assign rs = ir[7:4];
  assign rt = ir[3:0];
  assign imm_d = DATA_W'($signed(ir[7:0]));
  assign imm_a = ADDR_W'($signed(ir[7:0]));
  assign alu_wr = ir[15:12] <= 4'd4;
  assign alu_op = ir[14] ? ALU_ADD : alu_op_t'(ir[13:12]);
  assign alu_b = op == OP_ADDI ? imm_d : b;
  assign imem_addr = pc;
  assign dmem_addr = ADDR_W'(a);
  assign dmem_wdata = b;

  cpu_alu #(.DATA_W(DATA_W)) alu (.a(a), .b(alu_b), .op(alu_op), .result(alu_y), .flags(alu_f));

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH;
    else state <= state_nx;

  always_comb
    state_nx = state == FETCH ? (imem_req && imem_ack ? DECODE : FETCH)
      : state == DECODE ? EXEC
      : state == EXEC ? (op == OP_LD || op == OP_ST ? MEM : op == OP_HALT ? HALTED : FETCH)
      : state == MEM ? (dmem_req && dmem_ack ? FETCH : MEM)
      : HALTED;

  // live keeps the fetch request low for the first cycle out of reset
  always_comb begin
    imem_req = live && state == FETCH;
    dmem_req = state == MEM;
    dmem_we = dmem_req && op == OP_ST;
    halted = state == HALTED;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      live <= 1'b0;
      pc <= RESET_PC;
      ir <= '0;
      a <= '0;
      b <= '0;
      flags <= '0;
      show_valid <= 1'b0;
      show_sel <= '0;
      show_data <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      live <= 1'b1;
      show_valid <= 1'b0;
      if (imem_req && imem_ack) begin
        ir <= imem_rdata;
        pc <= pc + ADDR_W'(1);
      end
      if (state == DECODE) begin
        a <= op == OP_ADDI ? regs[rd] : regs[rs];
        b <= op == OP_ST ? regs[rd] : regs[rt];
      end
      if (state == EXEC) begin
        if (alu_wr) begin
          regs[rd] <= alu_y;
          flags <= alu_f;
        end
        if (op == OP_LDI) regs[rd] <= imm_d;
        if (op == OP_JMP || (op == OP_BZ && flags.z)) pc <= pc + imm_a;
        if (op == OP_SHOW) begin
          show_valid <= 1'b1;
          show_sel <= rd[1:0];
          show_data <= a;
        end
      end
      if (dmem_req && dmem_ack && op == OP_LD) regs[rd] <= dmem_rdata;
    end
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: directed programs against wait-state memory models, 8-bit and 16/10-bit builds
module tb_multicycle_cpu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, show_valid, halted;
  logic [7:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, show_data;
  logic [15:0] imem_rdata;
  logic [1:0] show_sel;
  logic [15:0] imem [256];
  logic [7:0] dmem [256];
  int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
  int cyc_ctr = 0, writes = 0, fe_hits = 0, unstable = 0, shows = 0;
  int tf [256];
  logic [7:0] last_fetch = '0;
  logic preq = 1'b0, pack = 1'b0;
  logic [16:0] pbus = '0;

  logic imem_req16, dmem_req16, dmem_we16, show_valid16, halted16;
  logic [9:0] imem_addr16, dmem_addr16, last_fetch16 = '0;
  logic [15:0] imem_rdata16, dmem_wdata16, show_data16;
  logic [1:0] show_sel16;
  logic [15:0] imem16 [1024];

  typedef struct {
    logic [15:0] i0, i1, i2;
    int r;
    logic [7:0] val;
    logic [3:0] fl;
    string name;
  } vec_t;
  vec_t vecs [11];

  int total = 0, bad = 0;

  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];
  assign imem_ack = icnt >= iwait;
  assign dmem_ack = dcnt >= dwait;
  assign imem_rdata16 = imem16[imem_addr16];

  multicycle_cpu #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'hF0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .show_valid(show_valid), .show_sel(show_sel), .show_data(show_data), .halted(halted)
  );

  multicycle_cpu #(.DATA_W(16), .ADDR_W(10)) dut16 (
    .clk(clk), .reset(reset),
    .imem_req(imem_req16), .imem_addr(imem_addr16), .imem_rdata(imem_rdata16), .imem_ack(1'b1),
    .dmem_req(dmem_req16), .dmem_we(dmem_we16), .dmem_addr(dmem_addr16), .dmem_wdata(dmem_wdata16),
    .dmem_rdata(16'h0000), .dmem_ack(1'b1),
    .show_valid(show_valid16), .show_sel(show_sel16), .show_data(show_data16), .halted(halted16)
  );

  always @(posedge clk) begin
    cyc_ctr <= cyc_ctr + 1;
    icnt <= imem_req && !imem_ack ? icnt + 1 : 0;
    dcnt <= dmem_req && !dmem_ack ? dcnt + 1 : 0;
    if (imem_req && imem_ack) begin
      tf[imem_addr] <= cyc_ctr;
      last_fetch <= imem_addr;
      if (imem_addr == 8'hFE) fe_hits <= fe_hits + 1;
    end
    if (dmem_req && dmem_ack && dmem_we) begin
      dmem[dmem_addr] <= dmem_wdata;
      writes <= writes + 1;
    end
    if (imem_req16) last_fetch16 <= imem_addr16;
  end

  // a request still waiting for ack must present the same address/data/we as last cycle
  always @(negedge clk) begin
    if (dmem_req && preq && !pack && {dmem_addr, dmem_wdata, dmem_we} != pbus) unstable <= unstable + 1;
    preq <= dmem_req;
    pack <= dmem_ack;
    pbus <= {dmem_addr, dmem_wdata, dmem_we};
    if (show_valid) shows <= shows + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [15:0] w0, w1, w2, w3, w4);
    for (int k = 0; k < 256; k++) imem[k] = 16'hF000;
    imem[8'hF0] = w0;
    imem[8'hF1] = w1;
    imem[8'hF2] = w2;
    imem[8'hF3] = w3;
    imem[8'hF4] = w4;
  endtask

  task automatic run(output int n);
    bit started = 1'b0;
    n = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3000 && !halted; k++) begin
      @(negedge clk);
      if (imem_req) started = 1'b1;
      if (started && !halted) n++;
    end
    chk("halt_reached", halted, 1'b1);
  endtask

  initial begin
    int c, s0, w0, u0, f0;
    vecs[0]  = '{16'h5105, 16'h5203, 16'h1312, 3, 8'h02, 4'b0010, "sub"};
    vecs[1]  = '{16'h517F, 16'h4101, 16'hB000, 1, 8'h80, 4'b1001, "addi_ovf"};
    vecs[2]  = '{16'h5103, 16'h5203, 16'h1312, 3, 8'h00, 4'b0110, "sub_zero"};
    vecs[3]  = '{16'h5180, 16'h5201, 16'h1312, 3, 8'h7F, 4'b0011, "sub_ovf"};
    vecs[4]  = '{16'h510C, 16'h520A, 16'h2312, 3, 8'h08, 4'b0000, "and"};
    vecs[5]  = '{16'h5180, 16'h5201, 16'h3312, 3, 8'h81, 4'b1000, "or"};
    vecs[6]  = '{16'h5102, 16'h5203, 16'h1312, 3, 8'hFF, 4'b1000, "sub_borrow"};
    vecs[7]  = '{16'h5100, 16'h4100, 16'h52FB, 2, 8'hFB, 4'b0100, "ldi_keeps_flags"};
    vecs[8]  = '{16'h51F0, 16'h5220, 16'h0312, 3, 8'h10, 4'b0010, "add_carry"};
    vecs[9]  = '{16'h5107, 16'hC1FF, 16'hD100, 1, 8'h07, 4'b0000, "nop_ops"};
    vecs[10] = '{16'h5105, 16'h41FE, 16'hB000, 1, 8'h03, 4'b0010, "addi_neg"};

    for (int k = 0; k < 1024; k++) imem16[k] = 16'hF000;
    imem16[0] = 16'h51FE;
    imem16[1] = 16'h527F;
    imem16[2] = 16'h427F;
    imem16[3] = 16'h90FB;
    load(16'h5105, 16'h5203, 16'h1312, 16'hA130, 16'hF000);

    @(negedge clk);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, 8'hF0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_show_valid", show_valid, 1'b0);
    chk("rst_dmem_wdata", dmem_wdata, 8'h00);

    s0 = shows;
    run(c);
    chk("prog_cycles", c, 15);
    chk("prog_show_pulses", shows - s0, 1);
    chk("prog_show_sel", show_sel, 2'd1);
    chk("prog_show_data", show_data, 8'h02);
    chk("prog_flags", dut.flags, 4'b0010);

    reset = 1'b1;
    #1;
    chk("rst_show_data", show_data, 8'h00);
    chk("rst_show_sel", show_sel, 2'd0);
    chk("rst_halted_async", halted, 1'b0);

    iwait = 2;
    run(c);
    chk("fetch_wait_cycles", c, 25);
    chk("fetch_wait_show_data", show_data, 8'h02);
    iwait = 0;

    for (int i = 0; i < 11; i++) begin
      load(vecs[i].i0, vecs[i].i1, vecs[i].i2, 16'hF000, 16'hF000);
      run(c);
      chk($sformatf("%s_reg", vecs[i].name), dut.regs[vecs[i].r], vecs[i].val);
      chk($sformatf("%s_flags", vecs[i].name), dut.flags, vecs[i].fl);
      chk($sformatf("%s_cycles", vecs[i].name), c, 12);
    end

    for (int k = 0; k < 100 && !halted16; k++) @(negedge clk);
    chk("w16_halted", halted16, 1'b1);
    chk("w16_ldi_neg", dut16.regs[1], 16'hFFFE);
    chk("w16_addi", dut16.regs[2], 16'h00FE);
    chk("w16_flags", dut16.flags, 4'b0000);
    chk("w16_pc_wrap", last_fetch16, 10'h3FF);

    load(16'h900C, 16'hF000, 16'hF000, 16'hF000, 16'hF000);
    imem[8'hFD] = 16'h5103;
    imem[8'hFE] = 16'h41FF;
    imem[8'hFF] = 16'h8001;
    imem[8'h00] = 16'h90FD;
    imem[8'h01] = 16'hF000;
    f0 = fe_hits;
    run(c);
    chk("loop_addi_count", fe_hits - f0, 3);
    chk("loop_r1", dut.regs[1], 8'h00);
    chk("loop_flags", dut.flags, 4'b0110);
    chk("loop_halt_addr", last_fetch, 8'h01);

    dwait = 3;
    load(16'h5510, 16'h545A, 16'h7450, 16'h6650, 16'hF000);
    w0 = writes;
    u0 = unstable;
    run(c);
    chk("mem_writes", writes - w0, 1);
    chk("mem_stored", dmem[8'h10], 8'h5A);
    chk("mem_ld_r6", dut.regs[6], 8'h5A);
    chk("mem_stable", unstable - u0, 0);
    chk("mem_cpi_st", tf[8'hF3] - tf[8'hF2], 7);
    chk("mem_cpi_ld", tf[8'hF4] - tf[8'hF3], 7);
    chk("mem_cycles", c, 23);

    dwait = 4;
    load(16'h5510, 16'h5433, 16'h7450, 16'h6750, 16'hF000);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 300 && !(dmem_req && !dmem_we); k++) @(negedge clk);
    chk("mid_ld_req", dmem_req && !dmem_we, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_dmem_req", dmem_req, 1'b0);
    chk("mid_rst_imem_req", imem_req, 1'b0);
    chk("mid_rst_pc", imem_addr, 8'hF0);
    chk("mid_rst_r7", dut.regs[7], 8'h00);
    run(c);
    chk("restart_cycles", c, 25);
    chk("restart_r7", dut.regs[7], 8'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
